sc_level_counter: RTL and testbench
===================================

Name: sc_level_counter

Overview:
- Responder to the general game state machine.
- Receives its active-low level-up request and clear strobes, holds the current game level, and returns the level-reached comparator flag the state machine branches on.
- Also produces the per-level game-speed tick: tick period shrinks as level rises. Downstream lane/traffic logic uses it.

Parameters:
- LEVEL_W, 4, width of level register.
- MAX_LEVEL, 9, final level; comparator asserts at this value; level saturates here.
- TICK_W, 26, width of speed prescaler.
- BASE_TICKS, 25000000, tick period in clocks at level 0.
- STEP_TICKS, 2500000, period reduction per level.
- MIN_TICKS, 2500000, floor on tick period (MIN_TICKS >= 2).

Ports:
- SC_STATEMACHINEGENERAL_CLOCK_50  in  1  system clock, 50 MHz.
- SC_STATEMACHINEGENERAL_RESET_InHigh  in  1  asynchronous, active-high reset.
- SC_LEVELCOUNTER_clear_InLow  in  1  synchronous clear from state machine, active low.
- SC_LEVELCOUNTER_contador_niveles_InLow  in  1  level-up request, active low, level-sensitive, held by requester.
- SC_LEVELCOUNTER_level_OutBus  out  LEVEL_W  current level, registered.
- SC_LEVELCOUNTER_COMPARATOR_LEVELS  out  1  high while level == MAX_LEVEL, registered.
- SC_LEVELCOUNTER_ack_OutHigh  out  1  one-cycle pulse acknowledging each accepted request.
- SC_LEVELCOUNTER_speedTick_OutHigh  out  1  one-cycle game-speed pulse.

Behaviour:
- Clock and reset: clock SC_STATEMACHINEGENERAL_CLOCK_50. Reset SC_STATEMACHINEGENERAL_RESET_InHigh is asynchronous, active-high.
- Reset values: level=0, COMPARATOR_LEVELS=0, ack=0, speedTick=0, prescaler=0, FSM=IDLE.
- All inputs are already synchronous to the clock. No synchronizers.

FSM (two states):
- IDLE: request low at edge k -> accept. At edge k:
  - level <= min(level+1, MAX_LEVEL).
  - ack <= 1 for exactly one cycle.
  - state <= WAIT_RELEASE.
  - Latency from request sample to updated level/ack: 1 clock.
- WAIT_RELEASE: stay while request low; no further counting; ack=0. Request high -> IDLE.
- Result: exactly one increment per low assertion regardless of its length. A request re-asserted after at least one high cycle counts again.

Saturation:
- Request accepted at level == MAX_LEVEL: level unchanged, ack still pulses, COMPARATOR_LEVELS stays 1.

Comparator:
- COMPARATOR_LEVELS is registered from the next-level value.
- Asserts on the same edge the level reaches MAX_LEVEL. No extra cycle.

Clear (clear_InLow == 0, synchronous, priority over request):
- level=0, COMPARATOR_LEVELS=0, prescaler=0, speedTick=0, ack=0.
- state <= WAIT_RELEASE if request is low in that cycle, else IDLE. A request held through clear is not counted.

Speed tick:
- period = max(BASE_TICKS - level*STEP_TICKS, MIN_TICKS).
- Product computed at TICK_W+LEVEL_W bits. Subtraction guarded against underflow: if level*STEP_TICKS >= BASE_TICKS - MIN_TICKS, use MIN_TICKS.
- Prescaler counts 0..period-1. When prescaler >= period-1: speedTick=1 for one cycle, prescaler wraps to 0.
- Tick period is therefore exactly `period` clocks.
- On any edge where level changes value, prescaler restarts at 0 and no tick is issued that cycle. A saturated request does not restart it.

Reset mid-operation:
- Asynchronous return to reset values in any state, including mid-WAIT_RELEASE or mid-count.
- Outputs are glitch-free registered signals.

Test Plan (BASE_TICKS=10, STEP_TICKS=2, MIN_TICKS=4, MAX_LEVEL=3, LEVEL_W=4, TICK_W=8):
1. Release reset, inputs high -> level=0, comparator=0. speedTick pulses every 10 clocks, first pulse on the 10th edge after reset release.
2. Request low for 5 cycles, then high; repeat once -> level 0->1->2. Exactly two ack pulses, each 1 clock after the request falls. Tick period becomes 8, then 6, counted from the increment edge.
3. Four separate requests from level 0 -> level 1,2,3,3. COMPARATOR_LEVELS rises on the edge level becomes 3. Fourth request gives ack with no level change. Period stays 4 (floor) with no prescaler restart on the fourth.
4. At level 3, clear low for 1 cycle with request also low, request held 3 more cycles -> level=0 and comparator=0 after that edge, no increment until request goes high then low again.
5. Reset asserted mid-count (prescaler=5) while FSM in WAIT_RELEASE -> all outputs 0 immediately. After release, first tick after 10 clocks; held-low request counts once (IDLE after reset).
6. Request pulse and clear low in the same cycle -> clear wins: level=0, ack=0.

Source files
------------

// File: rtl/sc_level_counter.sv
// sc_level_counter: game level register with edge-once request FSM, max-level flag and level-scaled speed tick
module sc_level_counter #(
    parameter int LEVEL_W    = 4,
    parameter int MAX_LEVEL  = 9,
    parameter int TICK_W     = 26,
    parameter int BASE_TICKS = 25000000,
    parameter int STEP_TICKS = 2500000,
    parameter int MIN_TICKS  = 2500000
) (
    input  logic               SC_STATEMACHINEGENERAL_CLOCK_50,
    input  logic               SC_STATEMACHINEGENERAL_RESET_InHigh,
    input  logic               SC_LEVELCOUNTER_clear_InLow,
    input  logic               SC_LEVELCOUNTER_contador_niveles_InLow,
    output logic [LEVEL_W-1:0] SC_LEVELCOUNTER_level_OutBus,
    output logic               SC_LEVELCOUNTER_COMPARATOR_LEVELS,
    output logic               SC_LEVELCOUNTER_ack_OutHigh,
    output logic               SC_LEVELCOUNTER_speedTick_OutHigh
);
    localparam logic [0:0] IDLE         = 1'b0;
    localparam logic [0:0] WAIT_RELEASE = 1'b1;
    localparam int PW = TICK_W + LEVEL_W;
    localparam logic [LEVEL_W-1:0] max_lvl = LEVEL_W'(MAX_LEVEL);
    localparam logic [PW-1:0] base_p = PW'(BASE_TICKS);
    localparam logic [PW-1:0] step_p = PW'(STEP_TICKS);
    localparam logic [PW-1:0] min_p  = PW'(MIN_TICKS);
    logic [0:0]         state;
    logic [TICK_W-1:0]  presc;
    logic [TICK_W-1:0]  period;
    logic [PW-1:0]      prod;
    logic [LEVEL_W-1:0] level_next;
    logic               req;
    logic               clr;
    logic               accept;
    logic               restart;
    logic               wrap;
    // product is widened so level*STEP never wraps before the floor comparison
    always_comb begin
        req        = !SC_LEVELCOUNTER_contador_niveles_InLow;
        clr        = !SC_LEVELCOUNTER_clear_InLow;
        accept     = state == IDLE && req;
        level_next = accept && SC_LEVELCOUNTER_level_OutBus != max_lvl ? SC_LEVELCOUNTER_level_OutBus + 1'b1 : SC_LEVELCOUNTER_level_OutBus;
        prod       = PW'(SC_LEVELCOUNTER_level_OutBus) * step_p;
        period     = prod >= base_p - min_p ? TICK_W'(MIN_TICKS) : TICK_W'(base_p - prod);
        restart    = level_next != SC_LEVELCOUNTER_level_OutBus;
        wrap       = presc >= period - 1'b1;
    end
    always_ff @(posedge SC_STATEMACHINEGENERAL_CLOCK_50 or posedge SC_STATEMACHINEGENERAL_RESET_InHigh) begin
        if (SC_STATEMACHINEGENERAL_RESET_InHigh) begin
            state                             <= IDLE;
            presc                             <= '0;
            SC_LEVELCOUNTER_level_OutBus      <= '0;
            SC_LEVELCOUNTER_COMPARATOR_LEVELS <= 1'b0;
            SC_LEVELCOUNTER_ack_OutHigh       <= 1'b0;
            SC_LEVELCOUNTER_speedTick_OutHigh <= 1'b0;
        end else if (clr) begin
            state                             <= req ? WAIT_RELEASE : IDLE;
            presc                             <= '0;
            SC_LEVELCOUNTER_level_OutBus      <= '0;
            SC_LEVELCOUNTER_COMPARATOR_LEVELS <= 1'b0;
            SC_LEVELCOUNTER_ack_OutHigh       <= 1'b0;
            SC_LEVELCOUNTER_speedTick_OutHigh <= 1'b0;
        end else begin
            state                             <= req ? WAIT_RELEASE : IDLE;
            presc                             <= restart || wrap ? '0 : presc + 1'b1;
            SC_LEVELCOUNTER_level_OutBus      <= level_next;
            SC_LEVELCOUNTER_COMPARATOR_LEVELS <= level_next == max_lvl;
            SC_LEVELCOUNTER_ack_OutHigh       <= accept;
            SC_LEVELCOUNTER_speedTick_OutHigh <= !restart && wrap;
        end
    end
endmodule

// File: tb/tb_sc_level_counter.sv
// tb_sc_level_counter: directed and random stimulus checked against a cycle model of level, ack and tick spacing
module tb_sc_level_counter;
    localparam int LEVEL_W = 4, MAX_LEVEL = 3, TICK_W = 8;
    localparam int BASE_TICKS = 10, STEP_TICKS = 2, MIN_TICKS = 4;
    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               clear_n = 1'b1;
    logic               req_n = 1'b1;
    logic [LEVEL_W-1:0] level;
    logic               comp;
    logic               ack;
    logic               tick;
    int  checks = 0;
    int  errors = 0;
    int  m_level, m_edges;
    bit  m_armed, m_ack, m_tick;
    sc_level_counter #(
        .LEVEL_W(LEVEL_W), .MAX_LEVEL(MAX_LEVEL), .TICK_W(TICK_W),
        .BASE_TICKS(BASE_TICKS), .STEP_TICKS(STEP_TICKS), .MIN_TICKS(MIN_TICKS)
    ) dut (
        .SC_STATEMACHINEGENERAL_CLOCK_50(clk),
        .SC_STATEMACHINEGENERAL_RESET_InHigh(rst),
        .SC_LEVELCOUNTER_clear_InLow(clear_n),
        .SC_LEVELCOUNTER_contador_niveles_InLow(req_n),
        .SC_LEVELCOUNTER_level_OutBus(level),
        .SC_LEVELCOUNTER_COMPARATOR_LEVELS(comp),
        .SC_LEVELCOUNTER_ack_OutHigh(ack),
        .SC_LEVELCOUNTER_speedTick_OutHigh(tick)
    );
    always #5 clk = ~clk;
    function automatic int period_of(int l);
        int p = BASE_TICKS - l * STEP_TICKS;
        return p < MIN_TICKS ? MIN_TICKS : p;
    endfunction
    task automatic check(string tag, int obs, int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask
    task automatic check_all(string tag);
        check({tag, ".level"}, int'(level), m_level);
        check({tag, ".comp"}, int'(comp), int'(m_level == MAX_LEVEL));
        check({tag, ".ack"}, int'(ack), int'(m_ack));
        check({tag, ".tick"}, int'(tick), int'(m_tick));
    endtask
    // a low request counts only if the request was seen high on the previous edge (or after reset)
    task automatic model(bit rq_n, bit cl_n);
        int nl;
        bit acc;
        if (!cl_n) begin
            m_level = 0; m_ack = 0; m_tick = 0; m_edges = 0; m_armed = rq_n;
        end else begin
            acc = m_armed && !rq_n;
            m_armed = rq_n;
            m_ack = acc;
            nl = acc ? (m_level + 1 > MAX_LEVEL ? MAX_LEVEL : m_level + 1) : m_level;
            if (nl != m_level) begin
                m_level = nl; m_edges = 0; m_tick = 0;
            end else begin
                m_edges++;
                m_tick = m_edges == period_of(m_level);
                if (m_tick) m_edges = 0;
            end
        end
    endtask
    task automatic step(string tag, bit rq_n, bit cl_n);
        req_n = rq_n;
        clear_n = cl_n;
        @(posedge clk);
        model(rq_n, cl_n);
        #1 check_all(tag);
    endtask
    task automatic async_reset(string tag);
        #2 rst = 1'b1;
        m_level = 0; m_ack = 0; m_tick = 0; m_edges = 0; m_armed = 1;
        #1 check_all(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask
    initial begin
        async_reset("reset");
        repeat (25) step("idle_tick10", 1, 1);
        repeat (2) begin
            repeat (5) step("press_hold", 0, 1);
            repeat (5) step("press_release", 1, 1);
        end
        repeat (12) step("period6", 1, 1);
        step("clear0", 1, 0);
        repeat (4) begin
            repeat (2) step("four_press", 0, 1);
            repeat (3) step("four_release", 1, 1);
        end
        repeat (12) step("floor4", 1, 1);
        step("clear_with_req", 0, 0);
        repeat (3) step("held_after_clear", 0, 1);
        step("release_after_clear", 1, 1);
        step("repress_after_clear", 0, 1);
        step("release2", 1, 1);
        repeat (6) step("wait_release_count", 0, 1);
        async_reset("mid_reset");
        repeat (3) step("held_after_reset", 0, 1);
        repeat (12) step("tick_after_reset", 1, 1);
        step("req_and_clear", 0, 0);
        step("release3", 1, 1);
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) == 0) req_n = ~req_n;
            step("random", req_n, $urandom_range(0, 39) != 0);
            if ($urandom_range(0, 299) == 0) async_reset("random_reset");
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
